cpu_controller: RTL

Multicycle control state machine for the 16-bit CPU. Sequences fetch, decode, execute, memory and writeback by driving enables and mux selects for the PC, instruction register, register file, ALU operand mux and memory port. Evaluates branch and jump conditions against the processor flags. ALU function selection stays with the ALU decoder; this block only gates when results are committed.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/cpu_controller_cond_eval.sv | 35 +++
 rtl/cpu_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU: controller states, opcode/opext fields,
// branch condition codes and the pc_src / wb_sel mux encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_LATCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEMRD  = 4'd4,
    S_LDWB   = 4'd5,
    S_MEMWR  = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MISC  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic is_itype(input logic [3:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_XORI, OP_ORI,
      OP_CMPI, OP_MOVI, OP_ADDUI, OP_LUI: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic imm_signed(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch/jump condition evaluator: combinational, cond[3:0] against flags {C,L,F,Z,N}.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c, l, f, z, n;
  assign {c, l, f, z, n} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_HI:   taken = l;
      CC_LS:   taken = !l;
      CC_GT:   taken = n;
      CC_LE:   taken = !n;
      CC_FS:   taken = f;
      CC_FC:   taken = !f;
      CC_LO:   taken = !l && !z;
      CC_HS:   taken = l || z;
      CC_LT:   taken = !n && !z;
      CC_GE:   taken = n || z;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the 16-bit CPU (fetch/decode/execute/memory/writeback).
// Define CTRL_MEM_WAIT_EN to add the mem_ready port and stall memory states on it.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [4:0]  flags,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        adr_sel,
  output logic        mem_write,
  output logic        mem_req,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic        imm_sign,
  output logic        flag_write
);

  state_t state, next_state;
  logic   taken, mem_ok, is_cmp, unused_bits;

  wire [3:0] opcode = instr[15:12];
  wire [3:0] cond   = instr[11:8];
  wire [3:0] opext  = instr[7:4];
  assign unused_bits = ^instr[3:0];

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign is_cmp = ((opcode == OP_RTYPE) && (opext == EXT_CMP)) || (opcode == OP_CMPI);

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    pc_src     = PC_INC;
    ir_write   = 1'b0;
    adr_sel    = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    alu_src_b  = 1'b0;
    imm_sign   = 1'b0;
    flag_write = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ok) next_state = S_LATCH;
      end
      S_LATCH: begin
        ir_write   = 1'b1;
        pc_en      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_SHIFT, OP_ADDI, OP_SUBI, OP_ANDI, OP_XORI,
          OP_ORI, OP_CMPI, OP_MOVI, OP_ADDUI, OP_LUI:
            next_state = S_EXEC;
          OP_MISC: begin
            case (opext)
              EXT_LOAD:           next_state = S_MEMRD;
              EXT_STOR:           next_state = S_MEMWR;
              EXT_JAL, EXT_JCOND: next_state = S_JUMP;
              default:            next_state = S_FETCH;
            endcase
          end
          OP_BCOND: next_state = S_BRANCH;
          default:  next_state = S_FETCH;
        endcase
      end
      S_EXEC: begin
        reg_write  = !is_cmp;
        flag_write = 1'b1;
        alu_src_b  = is_itype(opcode);
        imm_sign   = imm_signed(opcode);
        next_state = S_FETCH;
      end
      S_MEMRD: begin
        adr_sel = 1'b1;
        mem_req = 1'b1;
        if (mem_ok) next_state = S_LDWB;
      end
      S_LDWB: begin
        reg_write  = 1'b1;
        wb_sel     = WB_MEM;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        adr_sel   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) next_state = S_FETCH;
      end
      S_BRANCH: begin
        pc_src     = PC_DISP;
        pc_en      = taken;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src = PC_REG;
        if (opext == EXT_JAL) begin
          pc_en     = 1'b1;
          reg_write = 1'b1;
          wb_sel    = WB_PC;
        end else begin
          pc_en = taken;
        end
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Outputs are killed combinationally so no write can escape while reset is high.
    if (reset) begin
      {pc_en, pc_src, ir_write, adr_sel, mem_write, mem_req,
       reg_write, wb_sel, alu_src_b, imm_sign, flag_write} = '0;
    end
  end

endmodule
